// File: rtl/ysyx_24110015_pkg.sv
// rtl/ysyx_24110015_pkg.sv - shared decode constants and encodings for the IDU
package ysyx_24110015_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [4:0] {
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM
   } op_e;

   typedef enum logic [2:0] {
      IT_R, IT_I, IT_S, IT_B, IT_U, IT_J, IT_SYS
   } itype_e;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

endpackage

// File: rtl/ysyx_24110015_imm_gen.sv
// rtl/ysyx_24110015_imm_gen.sv - combinational immediate extraction by format class
module ysyx_24110015_imm_gen
   import ysyx_24110015_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     inst,
   input  itype_e          itype,
   output logic [XLEN-1:0] imm
);

   logic [31:0] w_imm32;

   // SYS shares the I layout so the CSR/funct12 field is visible downstream
   always_comb begin
      w_imm32 = 32'b0;
      case (itype)
         IT_I, IT_SYS: w_imm32 = {{20{inst[31]}}, inst[31:20]};
         IT_S:         w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IT_B:         w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IT_U:         w_imm32 = {inst[31:12], 12'b0};
         IT_J:         w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:      w_imm32 = 32'b0;
      endcase
   end

   assign imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/ysyx_24110015_idu.sv
// rtl/ysyx_24110015_idu.sv - RV32E decode stage with a single valid/ready pipeline register
module ysyx_24110015_idu
   import ysyx_24110015_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter bit RV32E = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic [2:0]      out_itype,
   output logic [4:0]      out_op,
   output logic [XLEN-1:0] out_imm,
   output logic            out_illegal,
   output logic            out_ebreak
);

   logic            r_v;
   logic [XLEN-1:0] r_pc;
   logic [4:0]      r_rs1, r_rs2, r_rd;
   logic [2:0]      r_funct3;
   logic            r_funct7b5;
   logic [2:0]      r_itype;
   logic [4:0]      r_op;
   logic [XLEN-1:0] r_imm;
   logic            r_illegal;
   logic            r_ebreak;

   op_e             w_op;
   itype_e          w_itype;
   logic            w_bad_opc;
   logic            w_use_rs1, w_use_rs2, w_use_rd;
   logic            w_reg_bad;
   logic [XLEN-1:0] w_imm_raw;
   logic            w_accept;

   always_comb begin
      w_op      = OP_OPIMM;
      w_itype   = IT_I;
      w_bad_opc = 1'b0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      case (in_inst[6:0])
         OPC_LUI:    begin w_op = OP_LUI;    w_itype = IT_U;   w_use_rd = 1'b1; end
         OPC_AUIPC:  begin w_op = OP_AUIPC;  w_itype = IT_U;   w_use_rd = 1'b1; end
         OPC_JAL:    begin w_op = OP_JAL;    w_itype = IT_J;   w_use_rd = 1'b1; end
         OPC_JALR:   begin w_op = OP_JALR;   w_itype = IT_I;   w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
         OPC_BRANCH: begin w_op = OP_BRANCH; w_itype = IT_B;   w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
         OPC_LOAD:   begin w_op = OP_LOAD;   w_itype = IT_I;   w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
         OPC_STORE:  begin w_op = OP_STORE;  w_itype = IT_S;   w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
         OPC_OPIMM:  begin w_op = OP_OPIMM;  w_itype = IT_I;   w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
         OPC_OP:     begin w_op = OP_OP;     w_itype = IT_R;   w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
         OPC_SYSTEM: begin w_op = OP_SYSTEM; w_itype = IT_SYS; w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
         default:    w_bad_opc = 1'b1;
      endcase
   end

   // Only index fields the format actually reads can make an RV32E instruction illegal
   assign w_reg_bad = RV32E && ((w_use_rs1 && in_inst[19]) ||
                                (w_use_rs2 && in_inst[24]) ||
                                (w_use_rd  && in_inst[11]));

   ysyx_24110015_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst  (in_inst[31:7]),
      .itype (w_itype),
      .imm   (w_imm_raw)
   );

   assign in_ready = !r_v || out_ready;
   assign w_accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v        <= 1'b0;
         r_pc       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_funct3   <= '0;
         r_funct7b5 <= 1'b0;
         r_itype    <= '0;
         r_op       <= '0;
         r_imm      <= '0;
         r_illegal  <= 1'b0;
         r_ebreak   <= 1'b0;
      end else begin
         if (flush)         r_v <= 1'b0;
         else if (w_accept) r_v <= 1'b1;
         else if (out_ready) r_v <= 1'b0;
         if (w_accept) begin
            r_pc       <= in_pc;
            r_rs1      <= in_inst[19:15];
            r_rs2      <= in_inst[24:20];
            r_rd       <= in_inst[11:7];
            r_funct3   <= in_inst[14:12];
            r_funct7b5 <= in_inst[30];
            r_itype    <= w_itype;
            r_op       <= w_op;
            r_imm      <= w_bad_opc ? '0 : w_imm_raw;
            r_illegal  <= w_bad_opc || w_reg_bad;
            r_ebreak   <= (in_inst == EBREAK);
         end
      end
   end

   assign out_valid    = r_v;
   assign out_pc       = r_pc;
   assign out_rs1      = r_rs1;
   assign out_rs2      = r_rs2;
   assign out_rd       = r_rd;
   assign out_funct3   = r_funct3;
   assign out_funct7b5 = r_funct7b5;
   assign out_itype    = r_itype;
   assign out_op       = r_op;
   assign out_imm      = r_imm;
   assign out_illegal  = r_illegal;
   assign out_ebreak   = r_ebreak;

endmodule

// File: tb/tb_ysyx_24110015_idu.sv
// tb/tb_ysyx_24110015_idu.sv - self-checking bench for the decode stage
module tb_ysyx_24110015_idu;
   import ysyx_24110015_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid, out_funct7b5, out_illegal, out_ebreak;
   logic [31:0] out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd, out_op;
   logic [2:0]  out_funct3, out_itype;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   ysyx_24110015_idu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
      .out_itype(out_itype), .out_op(out_op), .out_imm(out_imm),
      .out_illegal(out_illegal), .out_ebreak(out_ebreak)
   );

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  itype;
      logic [4:0]  op;
      logic        ill, ebr;
      logic [2:0]  f3;
      logic        f7;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   vec_t       vecs[7];
   logic [6:0] opcs[10];
   logic       m_v;
   exp_t       m_e;
   logic [31:0] m_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bundle(input string tag, input exp_t e, input logic [31:0] pc);
      chk({tag, "_pc"},      out_pc, pc);
      chk({tag, "_imm"},     out_imm, e.imm);
      chk({tag, "_rd"},      32'(out_rd), 32'(e.rd));
      chk({tag, "_rs1"},     32'(out_rs1), 32'(e.rs1));
      chk({tag, "_rs2"},     32'(out_rs2), 32'(e.rs2));
      chk({tag, "_itype"},   32'(out_itype), 32'(e.itype));
      chk({tag, "_op"},      32'(out_op), 32'(e.op));
      chk({tag, "_illegal"}, 32'(out_illegal), 32'(e.ill));
      chk({tag, "_ebreak"},  32'(out_ebreak), 32'(e.ebr));
      chk({tag, "_funct3"},  32'(out_funct3), 32'(e.f3));
      chk({tag, "_funct7b5"}, 32'(out_funct7b5), 32'(e.f7));
   endtask

   // Reference decoder: format chosen by opcode, immediates rebuilt with shifts and masks
   function automatic exp_t ref_decode(input logic [31:0] inst);
      exp_t e;
      logic signed [31:0] s;
      logic [31:0] sh;
      logic u1, u2, ud;
      s = inst;
      e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
      e.f3 = inst[14:12]; e.f7 = inst[30];
      e.ebr = (inst == 32'h0010_0073);
      e.ill = 1'b0; e.imm = 32'd0;
      u1 = 1'b0; u2 = 1'b0; ud = 1'b0;
      e.op = OP_OPIMM; e.itype = IT_I;
      case (inst[6:0])
         7'h37: begin e.op = OP_LUI;    e.itype = IT_U;   ud = 1; end
         7'h17: begin e.op = OP_AUIPC;  e.itype = IT_U;   ud = 1; end
         7'h6F: begin e.op = OP_JAL;    e.itype = IT_J;   ud = 1; end
         7'h67: begin e.op = OP_JALR;   e.itype = IT_I;   u1 = 1; ud = 1; end
         7'h63: begin e.op = OP_BRANCH; e.itype = IT_B;   u1 = 1; u2 = 1; end
         7'h03: begin e.op = OP_LOAD;   e.itype = IT_I;   u1 = 1; ud = 1; end
         7'h23: begin e.op = OP_STORE;  e.itype = IT_S;   u1 = 1; u2 = 1; end
         7'h13: begin e.op = OP_OPIMM;  e.itype = IT_I;   u1 = 1; ud = 1; end
         7'h33: begin e.op = OP_OP;     e.itype = IT_R;   u1 = 1; u2 = 1; ud = 1; end
         7'h73: begin e.op = OP_SYSTEM; e.itype = IT_SYS; u1 = 1; ud = 1; end
         default: e.ill = 1'b1;
      endcase
      case (e.itype)
         IT_I, IT_SYS: begin sh = s >>> 20; e.imm = sh; end
         IT_S: begin sh = s >>> 20; e.imm = (sh & ~32'h1F) | 32'(inst[11:7]); end
         IT_B: begin sh = s >>> 19; e.imm = (sh & 32'hFFFF_F000) | (32'(inst[7]) << 11)
                                           | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1); end
         IT_U: e.imm = inst & 32'hFFFF_F000;
         IT_J: begin sh = s >>> 11; e.imm = (sh & 32'hFFF0_0000) | (inst & 32'h000F_F000)
                                           | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1); end
         default: e.imm = 32'd0;
      endcase
      if (e.ill) e.imm = 32'd0;
      if ((u1 && e.rs1 >= 16) || (u2 && e.rs2 >= 16) || (ud && e.rd >= 16)) e.ill = 1'b1;
      return e;
   endfunction

   initial begin
      logic [31:0] r;
      int sel;
      vecs[0] = '{32'h0050_0093, '{32'd5,        5'd1,  5'd0,  5'd5,  IT_I,   OP_OPIMM,  1'b0, 1'b0, 3'd0, 1'b0}};
      vecs[1] = '{32'h1234_5137, '{32'h12345000, 5'd2,  5'd8,  5'd3,  IT_U,   OP_LUI,    1'b0, 1'b0, 3'd5, 1'b0}};
      vecs[2] = '{32'hFFDF_F0EF, '{32'hFFFFFFFC, 5'd1,  5'd31, 5'd29, IT_J,   OP_JAL,    1'b0, 1'b0, 3'd7, 1'b1}};
      vecs[3] = '{32'hFE20_AC23, '{32'hFFFFFFF8, 5'd24, 5'd1,  5'd2,  IT_S,   OP_STORE,  1'b0, 1'b0, 3'd2, 1'b1}};
      vecs[4] = '{32'h0000_0000, '{32'd0,        5'd0,  5'd0,  5'd0,  IT_I,   OP_OPIMM,  1'b1, 1'b0, 3'd0, 1'b0}};
      vecs[5] = '{32'h0080_0833, '{32'd0,        5'd16, 5'd0,  5'd8,  IT_R,   OP_OP,     1'b1, 1'b0, 3'd0, 1'b0}};
      vecs[6] = '{32'h0010_0073, '{32'd1,        5'd0,  5'd0,  5'd1,  IT_SYS, OP_SYSTEM, 1'b0, 1'b1, 3'd0, 1'b0}};
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_pc = 32'd0; in_inst = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_illegal", 32'(out_illegal), 32'd0);
      chk("rst_ebreak", 32'(out_ebreak), 32'd0);
      chk("rst_imm", out_imm, 32'd0);
      rst = 1'b1;
      #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Table-driven single instructions, one per cycle
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1;
         in_inst = vecs[i].inst; in_pc = 32'h8000_0000 + 32'(i * 4);
         @(posedge clk); #1;
         in_valid = 1'b0;
         chk("vec_valid", 32'(out_valid), 32'd1);
         check_bundle($sformatf("vec%0d", i), vecs[i].e, 32'h8000_0000 + 32'(i * 4));
      end

      // Stall for three cycles with a new word waiting
      @(negedge clk);
      in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h1000; out_ready = 1'b1;
      @(posedge clk); #1;
      in_inst = 32'h1234_5137; in_pc = 32'h1004; out_ready = 1'b0;
      repeat (3) begin
         #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_pc", out_pc, 32'h1000);
         chk("stall_imm", out_imm, 32'd5);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_pc", out_pc, 32'h1004);
      chk("release_rd", 32'(out_rd), 32'd2);
      for (int k = 1; k <= 6; k++) begin
         in_inst = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
         in_pc = 32'h2000 + 32'(k * 4);
         @(posedge clk); #1;
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_pc", out_pc, 32'h2000 + 32'(k * 4));
         chk("stream_rd", 32'(out_rd), 32'(k));
         chk("stream_imm", out_imm, 32'(k));
      end

      // Flush while full with a word offered
      in_inst = 32'h0000_0113; in_pc = 32'hDEAD_0000; flush = 1'b1;
      #1 chk("flush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("flush_stays_empty", 32'(out_valid), 32'd0);
         chk("flush_dropped_pc", 32'(out_pc == 32'hDEAD_0000), 32'd0);
      end

      // Asynchronous reset while full
      in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h3000;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_pc", out_pc, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Random traffic against the reference model
      m_v = 1'b0; m_pc = 32'd0; m_e = ref_decode(32'd0);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         chk("rnd_valid", 32'(out_valid), 32'(m_v));
         if (m_v) check_bundle("rnd", m_e, m_pc);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         r = $urandom();
         if ($urandom_range(0, 1) == 1) r = r & ~32'h0108_0800;
         sel = $urandom_range(0, 11);
         in_inst = (sel < 10) ? {r[31:7], opcs[sel]} : r;
         if (sel == 11) in_inst = 32'h0010_0073;
         in_pc = $urandom();
         #1 chk("rnd_in_ready", 32'(in_ready), 32'(!m_v || out_ready));
         @(posedge clk);
         if (flush) m_v = 1'b0;
         else if (in_valid && (!m_v || out_ready)) begin
            m_v = 1'b1; m_e = ref_decode(in_inst); m_pc = in_pc;
         end else if (out_ready) m_v = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_24110015_idu.md
# ysyx_24110015_idu

Instruction decode stage, directly downstream of the fetch unit. It accepts one `{pc, inst}` pair per handshake, splits and decodes it (RV32E base integer set plus `ebreak`/`ecall`), and holds the decoded bundle in a single pipeline register for the execute stage. Valid/ready handshakes on both sides give full throughput under no backpressure. A flush input discards in-flight work when the front end is redirected.

## Interface
Parameters:
- `XLEN`, 32: datapath width of pc, inst and imm.
- `RV32E`, 1: when 1, any register index with bit 4 set is illegal.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `in_valid` in 1: fetch presents a valid `{in_pc, in_inst}`.
- `in_ready` out 1: the stage can accept this cycle.
- `in_pc` in XLEN: pc of the fetched instruction.
- `in_inst` in 32: instruction word.
- `flush` in 1: discard the held entry and any same-cycle input.
- `out_valid` out 1: decoded bundle is valid.
- `out_ready` in 1: execute consumes the bundle this cycle.
- `out_pc` out XLEN: pc of the bundle.
- `out_rs1`, `out_rs2`, `out_rd` out 5: register indices (`inst[19:15]`, `[24:20]`, `[11:7]`).
- `out_funct3` out 3: `inst[14:12]`.
- `out_funct7b5` out 1: `inst[30]`.
- `out_itype` out 3: format class, one of R/I/S/B/U/J/SYS.
- `out_op` out 5: opcode class. Values are package constants for LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM.
- `out_imm` out XLEN: sign-extended immediate; 0 for R-type.
- `out_illegal` out 1: unrecognised opcode or an RV32E register violation.
- `out_ebreak` out 1: inst == 0x00100073.

## Operation
- State is one valid bit, `v`, plus the payload register. The stage is either EMPTY (`v`=0) or FULL (`v`=1).
- `in_ready = !v || out_ready`. The stage accepts whenever the entry is empty or is being drained this cycle.
- Accept (`in_valid && in_ready && !flush`): the payload register loads the decoded fields and `v` is set to 1.
- Drain without accept (`out_valid && out_ready`, no accept): `v` is cleared to 0.
- Drain and accept in the same cycle: the new bundle replaces the old one and `v` stays 1.
- `flush` has top priority. In a flush cycle `v` goes to 0 and a concurrent `in_valid` is dropped. `in_ready` is still computed normally, so fetch sees its word as taken.
- Stall (`v`=1, `!out_ready`): the payload holds stable and `in_ready`=0.
- Immediate rules (all sign-extended from `inst[31]`):
  - I: `[31:20]`.
  - S: `{[31:25],[11:7]}`.
  - B: `{[31],[7],[30:25],[11:8],0}`.
  - U: `{[31:12],12'b0}`.
  - J: `{[31],[19:12],[20],[30:21],0}`.
- Register-use rules: for RV32E legality, unused index fields are ignored. U/J types check rd only. S/B types check rs1 and rs2 only.
- Illegal opcode: `out_op` = OPIMM, `out_imm` = 0, `out_illegal` = 1.
- Reset: `v`=0 and every payload output is 0, so `out_valid`=0, `out_illegal`=0 and `out_ebreak`=0. `in_ready`=1 while reset is deasserted and the stage is empty.
- Reset asserted mid-operation drops the held entry immediately, asynchronously.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` is combinational from `v` and `out_ready`. There is no combinational path from `in_*` to `out_*`.
- Once `out_valid`=1, all outputs hold stable until the handshake completes or a flush occurs.

## Structure
- Shared package `ysyx_24110015_pkg` holds:
  - the opcode constants (7-bit);
  - the `out_op` class encoding;
  - the `itype` encoding;
  - the `EBREAK`/`ECALL` constants.
- Sub-module `ysyx_24110015_imm_gen` is purely combinational: `inst` and `itype` in, `imm` out.

## Test plan
- After reset: `out_valid`=0 and `in_ready`=1. Inject `in_inst`=0x00500093 (`addi x1,x0,5`) with pc=0x80000000. Next cycle: rd=1, rs1=0, imm=5, itype=I, op=OPIMM, pc=0x80000000.
- 0x12345137 (`lui x2,0x12345`) gives imm=0x12345000 and rd=2. 0xFFDFF0EF (`jal x1,-4`) gives imm=0xFFFFFFFC and itype=J. 0xFE20AC23 (`sw x2,-8(x1)`) gives imm=0xFFFFFFF8, rs1=1, rs2=2, itype=S.
- 0x00000000 gives `out_illegal`=1. 0x00800833 (`add x16,x0,x8`) with RV32E=1 gives illegal=1. 0x00100073 gives `out_ebreak`=1 and illegal=0.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1: `in_ready`=0 and the payload is unchanged. Release `out_ready`: streaming back-to-back inputs delivers one bundle per cycle in order, with no loss or duplication.
- Assert `flush` with the stage FULL and `in_valid`=1: the next cycle `out_valid`=0, and the dropped word never appears.
- Assert `rst`=0 asynchronously while FULL: `out_valid` falls before the next clock edge.
